npu_write_back: RTL and testbench
=================================

// Module: npu_write_back
// PURPOSE
//  Downstream of the layer memory-read/PE stage: takes 16 signed accumulator lanes per vector,
//  applies optional ReLU, requantizes (arithmetic right shift + saturate) to 8 bits, and
//  serializes the bytes into one image RAM bank at consecutive addresses.
//  Generates wr_en / ram_num / ram_store_addr for the top-level RAM write-back mux, plus a job-done pulse.
// PARAMETERS
//  LANES    16  lanes per input vector
//  ACC_W    20  signed accumulator width per lane
//  DATA_W   8   stored word width (signed two's complement)
//  ADDR_W   14  RAM address width
// PORTS
//  clk               in   1              rising-edge clock
//  reset             in   1              asynchronous, active-high reset
//  start_write_back  in   1              job start pulse; sampled only in IDLE
//  base_addr         in   ADDR_W         first store address, latched on start
//  bank_sel          in   3              target RAM bank, latched on start
//  total_words       in   ADDR_W         bytes to write this job, latched on start
//  shift             in   4              requant right-shift amount, latched on start
//  relu_en           in   1              1 = clamp negative lanes to 0, latched on start
//  in_valid          in   1              input vector valid
//  in_ready          out  1              stage can accept a vector
//  in_data           in   LANES*ACC_W    packed signed lanes, lane 0 in LSBs
//  wr_en             out  1              RAM write strobe
//  ram_num           out  3              bank being written
//  ram_store_addr    out  ADDR_W         write address
//  wr_data           out  DATA_W         write data
//  busy              out  1              high from start acceptance until the cycle after DONE
//  stop_write_back   out  1              one-cycle pulse: job complete
//  sat_flag          out  1              sticky: a lane saturated this job; cleared on start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; lane buffer, counters and latched config cleared.
//  FSM states: IDLE, WAIT_IN, DRAIN, DONE. All outputs registered.
//  IDLE: in_ready=0. start_write_back=1 -> latch config, clear sat_flag, written=0, busy=1;
//    next state WAIT_IN, or DONE if total_words==0.
//  WAIT_IN: in_ready=1. On in_valid & in_ready, quantize all lanes into buffer, lane_idx=0 -> DRAIN.
//  DRAIN: in_ready=0. Each cycle: wr_en=1, wr_data=buf[lane_idx], ram_num=bank,
//    ram_store_addr=(base_addr+written) mod 2^ADDR_W; written++, lane_idx++.
//    If this write makes written==total_words -> DONE (remaining lanes discarded);
//    else if lane_idx==LANES-1 -> WAIT_IN.
//  DONE: stop_write_back=1 for exactly one cycle, wr_en=0 -> IDLE; busy=0 from next cycle.
//  Latency: vector accepted at edge t -> first wr_en high in cycle t+1; 16 writes on consecutive cycles.
//    Sustained throughput: 16 bytes per 17 cycles.
//  Quantize per lane: v = relu_en & x<0 ? 0 : x; q = v >>> shift (arithmetic, floor);
//    saturate q to [-128,127]; sat_flag set if clamping occurred (ReLU clamp is not saturation).
//  start_write_back outside IDLE (including DONE cycle) ignored. in_valid outside WAIT_IN ignored.
//  Config inputs are don't-care after latching; changes mid-job have no effect.
//  Address wraps modulo 2^ADDR_W; no error flag for wrap.
//  Reset mid-job: immediate abort; wr_en, busy, stop_write_back drop to 0; no done pulse.
// TESTING
//  1 Reset held: all outputs 0, in_ready=0; release, idle 10 cycles -> no wr_en.
//  2 base=100, bank=2, total=16, shift=2, relu=0, lane k=4k -> 16 writes addr 100+k, data k,
//    ram_num=2; stop pulse the cycle after write to 115; sat_flag=0.
//  3 Lanes -600 (shift 0, relu 0) -> 0x80 and sat_flag=1; same with relu=1 -> 0x00, sat_flag=0;
//    lane 1000 -> 0x7F, sat_flag=1; lane -5 shift 1 -> 0xFD (floor).
//  4 total=20, two vectors -> 20 writes addr base..base+19; second vector lanes 4-15 dropped;
//    in_ready low during DRAIN, one cycle high between vectors with in_valid held.
//  5 base=16380, total=16 -> addresses 16380..16383 then 0..11.
//  6 Reset asserted after 5 DRAIN writes -> wr_en/busy 0 immediately, no stop pulse;
//    start pulsed while busy ignored; total=0 -> stop pulse 1 cycle after start, no writes.

Source files
------------

// File: rtl/npu_write_back_if.sv
// Write-back stage bus: job configuration, accumulator vector handshake, RAM write port and status.
interface npu_write_back_if #(
   parameter int LANES  = 16,
   parameter int ACC_W  = 20,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
);
   logic                     start_write_back;
   logic [ADDR_W-1:0]        base_addr;
   logic [2:0]               bank_sel;
   logic [ADDR_W-1:0]        total_words;
   logic [3:0]               shift;
   logic                     relu_en;
   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*ACC_W-1:0]   in_data;
   logic                     wr_en;
   logic [2:0]               ram_num;
   logic [ADDR_W-1:0]        ram_store_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     busy;
   logic                     stop_write_back;
   logic                     sat_flag;

   modport master (
      output start_write_back, base_addr, bank_sel, total_words, shift, relu_en,
      output in_valid, in_data,
      input  in_ready, wr_en, ram_num, ram_store_addr, wr_data, busy, stop_write_back, sat_flag
   );

   modport slave (
      input  start_write_back, base_addr, bank_sel, total_words, shift, relu_en,
      input  in_valid, in_data,
      output in_ready, wr_en, ram_num, ram_store_addr, wr_data, busy, stop_write_back, sat_flag
   );
endinterface

// File: rtl/npu_write_back.sv
// Requantizes 16-lane accumulator vectors to int8 and streams the bytes into one RAM bank.
// First write one cycle after vector acceptance; in_ready stays low while a vector drains.
module npu_write_back #(
   parameter int LANES  = 16,
   parameter int ACC_W  = 20,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input logic             clk,
   input logic             reset,
   npu_write_back_if.slave bus
);
   localparam int LW = $clog2(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

   typedef enum logic [1:0] {IDLE, WAIT_IN, DRAIN, DONE} state_t;
   state_t state, nxt_state;

   logic [ADDR_W-1:0] base_r, total_r;
   logic [2:0]        bank_r;
   logic [3:0]        shift_r;
   logic              relu_r;
   logic [ADDR_W-1:0] written, nxt_written;
   logic [LW-1:0]     lane_idx, nxt_lane;
   logic [DATA_W-1:0] lane_buf [LANES];
   logic [DATA_W-1:0] q_lane [LANES];
   logic [LANES-1:0]  q_sat;
   logic              start_acc, accept;

   logic              wr_en_r, in_ready_r, busy_r, stop_r, sat_r;
   logic [2:0]        ram_num_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              nxt_wr_en, nxt_in_ready, nxt_busy, nxt_stop, nxt_sat;
   logic [2:0]        nxt_ram_num;
   logic [ADDR_W-1:0] nxt_addr;
   logic [DATA_W-1:0] nxt_wr_data;

   // Returns {saturated, byte}; a ReLU clamp to zero never counts as saturation.
   function automatic logic [DATA_W:0] quantize(input logic signed [ACC_W-1:0] x,
                                                input logic [3:0] sh, input logic relu);
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] s;
      logic [DATA_W:0]         res;
      v = (relu && x[ACC_W-1]) ? '0 : x;
      s = v >>> sh;
      if (s > Q_MAX)      res = {1'b1, Q_MAX[DATA_W-1:0]};
      else if (s < Q_MIN) res = {1'b1, Q_MIN[DATA_W-1:0]};
      else                res = {1'b0, s[DATA_W-1:0]};
      return res;
   endfunction

   always_comb begin
      for (int k = 0; k < LANES; k++)
         {q_sat[k], q_lane[k]} = quantize(bus.in_data[k*ACC_W +: ACC_W], shift_r, relu_r);
   end

   always_comb begin
      nxt_state   = state;
      nxt_written = written;
      nxt_lane    = lane_idx;
      nxt_sat     = sat_r;
      start_acc   = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_write_back) begin
               start_acc   = 1'b1;
               nxt_written = '0;
               nxt_sat     = 1'b0;
               nxt_state   = (bus.total_words == '0) ? DONE : WAIT_IN;
            end
         end
         WAIT_IN: begin
            if (bus.in_valid && in_ready_r) begin
               accept    = 1'b1;
               nxt_lane  = '0;
               nxt_sat   = sat_r | (|q_sat);
               nxt_state = DRAIN;
            end
         end
         DRAIN: begin
            nxt_written = written + 1'b1;
            if (nxt_written == total_r)
               nxt_state = DONE;
            else if (lane_idx == LAST_LANE)
               nxt_state = WAIT_IN;
            else
               nxt_lane = lane_idx + 1'b1;
         end
         DONE: nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase

      // Output registers are loaded with what the next state presents.
      nxt_wr_en    = (nxt_state == DRAIN);
      nxt_in_ready = (nxt_state == WAIT_IN);
      nxt_busy     = (nxt_state != IDLE);
      nxt_stop     = (nxt_state == DONE);
      nxt_ram_num  = nxt_wr_en ? bank_r : '0;
      nxt_addr     = nxt_wr_en ? ADDR_W'(base_r + nxt_written) : '0;
      nxt_wr_data  = '0;
      if (nxt_wr_en)
         nxt_wr_data = accept ? q_lane[0] : lane_buf[nxt_lane];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         written    <= '0;
         lane_idx   <= '0;
         base_r     <= '0;
         total_r    <= '0;
         bank_r     <= '0;
         shift_r    <= '0;
         relu_r     <= 1'b0;
         for (int k = 0; k < LANES; k++) lane_buf[k] <= '0;
         wr_en_r    <= 1'b0;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         stop_r     <= 1'b0;
         sat_r      <= 1'b0;
         ram_num_r  <= '0;
         addr_r     <= '0;
         wr_data_r  <= '0;
      end else begin
         state    <= nxt_state;
         written  <= nxt_written;
         lane_idx <= nxt_lane;
         if (start_acc) begin
            base_r  <= bus.base_addr;
            total_r <= bus.total_words;
            bank_r  <= bus.bank_sel;
            shift_r <= bus.shift;
            relu_r  <= bus.relu_en;
         end
         if (accept)
            for (int k = 0; k < LANES; k++) lane_buf[k] <= q_lane[k];
         wr_en_r    <= nxt_wr_en;
         in_ready_r <= nxt_in_ready;
         busy_r     <= nxt_busy;
         stop_r     <= nxt_stop;
         sat_r      <= nxt_sat;
         ram_num_r  <= nxt_ram_num;
         addr_r     <= nxt_addr;
         wr_data_r  <= nxt_wr_data;
      end
   end

   assign bus.wr_en           = wr_en_r;
   assign bus.in_ready        = in_ready_r;
   assign bus.busy            = busy_r;
   assign bus.stop_write_back = stop_r;
   assign bus.sat_flag        = sat_r;
   assign bus.ram_num         = ram_num_r;
   assign bus.ram_store_addr  = addr_r;
   assign bus.wr_data         = wr_data_r;
endmodule

// File: tb/tb_npu_write_back.sv
// Directed bench for npu_write_back: table of single-vector jobs plus multi-vector, empty-job and reset sequences.
module tb_npu_write_back;
   localparam int LANES  = 16;
   localparam int ACC_W  = 20;
   localparam int ADDR_W = 14;

   typedef struct {
      int base; int bank; int total; int shift; int relu;
      int x0;   int dx;               // lane k input = x0 + k*dx
      int e0;   int de;               // expected byte k = e0 + k*de (8-bit)
      int sat;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   npu_write_back_if bus ();
   npu_write_back dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic set_lanes(input int x0, input int dx);
      for (int k = 0; k < LANES; k++) bus.in_data[k*ACC_W +: ACC_W] = ACC_W'(x0 + k*dx);
   endtask

   task automatic run_job(input rec_t r, input int id);
      logic [ADDR_W-1:0] ea;
      logic [7:0]        ed;
      @(negedge clk);
      bus.base_addr = ADDR_W'(r.base);  bus.bank_sel = 3'(r.bank);
      bus.total_words = ADDR_W'(r.total); bus.shift = 4'(r.shift);
      bus.relu_en = 1'(r.relu);         bus.start_write_back = 1'b1;
      @(negedge clk);
      bus.start_write_back = 1'b0;
      check($sformatf("job%0d busy/ready/wr/sat", id),
            {bus.busy, bus.in_ready, bus.wr_en, bus.sat_flag}, 4'b1100);
      bus.in_valid = 1'b1;
      set_lanes(r.x0, r.dx);
      for (int k = 0; k < r.total; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.start_write_back = 1'b0;
         ea = ADDR_W'(r.base + k);
         ed = 8'(r.e0 + k*r.de);
         check($sformatf("job%0d write%0d {rdy,wr,bank,addr,data}", id, k),
               {bus.in_ready, bus.wr_en, bus.ram_num, bus.ram_store_addr, bus.wr_data},
               {1'b0, 1'b1, 3'(r.bank), ea, ed});
         if (k == r.total/2) begin
            // Start and config changes mid-job must be ignored.
            bus.start_write_back = 1'b1; bus.base_addr = '0; bus.total_words = '0;
            bus.bank_sel = ~3'(r.bank);  bus.shift = 4'd7; bus.relu_en = ~bus.relu_en;
         end
      end
      @(negedge clk);
      bus.start_write_back = 1'b0;
      check($sformatf("job%0d done {stop,busy,wr,sat}", id),
            {bus.stop_write_back, bus.busy, bus.wr_en, bus.sat_flag}, {3'b110, 1'(r.sat)});
      bus.total_words = ADDR_W'(3);
      bus.start_write_back = 1'b1;           // lands on the DONE cycle
      @(negedge clk);
      bus.start_write_back = 1'b0;
      check($sformatf("job%0d idle {stop,busy,wr,rdy}", id),
            {bus.stop_write_back, bus.busy, bus.wr_en, bus.in_ready}, 4'b0000);
   endtask

   rec_t tbl [11];
   int   cnt;

   initial begin
      tbl[0]  = '{100,   2, 16, 2,  0, 0,       4,   0,     1,  0};
      tbl[1]  = '{500,   1, 16, 0,  0, -600,    0,   'h80,  0,  1};
      tbl[2]  = '{500,   1, 16, 0,  1, -600,    0,   0,     0,  0};
      tbl[3]  = '{600,   3, 16, 0,  0, 1000,    0,   'h7F,  0,  1};
      tbl[4]  = '{700,   4, 16, 1,  0, -5,      0,   'hFD,  0,  0};
      tbl[5]  = '{16380, 6, 16, 0,  0, -8,      1,   'hF8,  1,  0};
      tbl[6]  = '{40,    7, 16, 4,  0, -2048,   256, 'h80,  16, 0};
      tbl[7]  = '{0,     0, 16, 15, 0, -524288, 0,   'hF0,  0,  0};
      tbl[8]  = '{900,   5, 5,  3,  1, 8,       8,   1,     1,  0};
      tbl[9]  = '{1000,  2, 16, 0,  0, 127,     0,   'h7F,  0,  0};
      tbl[10] = '{1100,  3, 16, 0,  0, -128,    0,   'h80,  0,  0};

      bus.start_write_back = 1'b0; bus.base_addr = '0; bus.bank_sel = '0;
      bus.total_words = '0; bus.shift = '0; bus.relu_en = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0;

      // Reset held, then idle.
      repeat (3) @(negedge clk);
      check("reset outputs", {bus.wr_en, bus.ram_num, bus.ram_store_addr, bus.wr_data,
                              bus.busy, bus.stop_write_back, bus.sat_flag, bus.in_ready}, '0);
      reset = 1'b0;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.wr_en || bus.busy || bus.in_ready) cnt++;
      end
      check("idle activity cycles", cnt, 0);

      for (int i = 0; i < 11; i++) run_job(tbl[i], i);

      // Two vectors, total 20, in_valid held across the gap.
      @(negedge clk);
      bus.base_addr = ADDR_W'(200); bus.bank_sel = 3'd5; bus.total_words = ADDR_W'(20);
      bus.shift = 4'd0; bus.relu_en = 1'b0; bus.start_write_back = 1'b1;
      @(negedge clk);
      bus.start_write_back = 1'b0;
      bus.in_valid = 1'b1;
      set_lanes(0, 1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) set_lanes(100, 1);
         check($sformatf("two-vec write%0d", k),
               {bus.in_ready, bus.wr_en, bus.ram_num, bus.ram_store_addr, bus.wr_data},
               {1'b0, 1'b1, 3'd5, ADDR_W'(200 + k), 8'(k)});
      end
      @(negedge clk);
      check("two-vec gap {rdy,wr}", {bus.in_ready, bus.wr_en}, 2'b10);
      for (int k = 16; k < 20; k++) begin
         @(negedge clk);
         check($sformatf("two-vec write%0d", k),
               {bus.in_ready, bus.wr_en, bus.ram_num, bus.ram_store_addr, bus.wr_data},
               {1'b0, 1'b1, 3'd5, ADDR_W'(200 + k), 8'(100 + k - 16)});
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("two-vec done {stop,wr,rdy}", {bus.stop_write_back, bus.wr_en, bus.in_ready}, 3'b100);
      @(negedge clk);
      check("two-vec idle {stop,busy}", {bus.stop_write_back, bus.busy}, 2'b00);

      // Empty job.
      @(negedge clk);
      bus.total_words = '0; bus.start_write_back = 1'b1;
      @(negedge clk);
      bus.start_write_back = 1'b0;
      check("empty job {stop,busy,wr,rdy}",
            {bus.stop_write_back, bus.busy, bus.wr_en, bus.in_ready}, 4'b1100);
      @(negedge clk);
      check("empty job after {stop,busy,wr}", {bus.stop_write_back, bus.busy, bus.wr_en}, 3'b000);

      // Reset after five writes.
      @(negedge clk);
      bus.base_addr = ADDR_W'(1000); bus.bank_sel = 3'd3; bus.total_words = ADDR_W'(16);
      bus.shift = 4'd0; bus.relu_en = 1'b0; bus.start_write_back = 1'b1;
      @(negedge clk);
      bus.start_write_back = 1'b0;
      bus.in_valid = 1'b1;
      set_lanes(1, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         check($sformatf("abort write%0d", k),
               {bus.wr_en, bus.ram_num, bus.ram_store_addr, bus.wr_data},
               {1'b1, 3'd3, ADDR_W'(1000 + k), 8'(k + 1)});
      end
      reset = 1'b1;
      #1;
      check("abort immediate {wr,busy,stop,rdy}",
            {bus.wr_en, bus.busy, bus.stop_write_back, bus.in_ready}, 4'b0000);
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.stop_write_back || bus.wr_en || bus.busy) cnt++;
      end
      check("abort activity cycles", cnt, 0);

      run_job(tbl[0], 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
